// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder: two NAND half-adder cells form a full adder per clock,
// operands consumed LSB-first, with start/busy/done handshake and held result flags.

module nand_half_adder (
    input  logic a,
    input  logic b,
    output logic p,   // carry
    output logic q    // sum
);
    logic n_ab;
    logic n_a;
    logic n_b;

    assign n_ab = ~(a & b);
    assign n_a  = ~(a & n_ab);
    assign n_b  = ~(b & n_ab);
    assign q    = ~(n_a & n_b);
    assign p    = ~n_ab;
endmodule

module serial_adder_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic s1, c1, s_bit, c2, carry_next;

    nand_half_adder u_ha_ab (
        .a (a_q[0]),
        .b (b_q[0]),
        .p (c1),
        .q (s1)
    );

    nand_half_adder u_ha_cy (
        .a (s1),
        .b (carry_q),
        .p (c2),
        .q (s_bit)
    );

    assign carry_next = c1 | c2;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start just like IDLE so operations can run back to back
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    count_d = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = carry_next;
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = carry_next;
                    ovf_d   = carry_q ^ carry_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit (WIDTH=4): arithmetic reference model with per-cycle
// compare, plus directed operations with hand-computed results.

module tb_serial_adder_unit;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {ovf, cout, sum[3:0]} from plain arithmetic
    function automatic logic [5:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] full;
        logic [3:0] low;
        full = 5'(a) + 5'(b) + 5'(c);
        low  = 4'(a[2:0]) + 4'(b[2:0]) + 4'(c);
        return {low[3] ^ full[4], full[4], full[3:0]};
    endfunction

    // Reference model: cycles left in the operation and the visible result
    int         m_left;
    logic       m_done;
    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic [5:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_pend <= '0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum  <= m_pend[3:0];
                m_cout <= m_pend[4];
                m_ovf  <= m_pend[5];
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
            end else if (start) begin
                m_left <= W;
                m_pend <= ref_add(a_in, b_in, cin);
                m_sum  <= '0;
                m_ovf  <= 1'b0;
            end
        end
    end

    // Per-cycle compare; sum is only meaningful outside RUN
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        if (m_left == 0) chk("sum", 32'(sum), 32'(m_sum));
    end

    task automatic wait_done(input string nm, output int cycles, output int nbusy);
        cycles = 0;
        nbusy  = 0;
        while (!done && cycles < 16) begin
            if (busy) nbusy++;
            @(negedge clk);
            cycles++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic do_op(input string nm, input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic ec, input logic eo);
        int cyc, nb;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, cyc, nb);
        chk({nm, "_busy_cycles"}, 32'(nb), 32'd4);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
        chk({nm, "_model_sum"}, 32'(m_sum), 32'(es));
    endtask

    initial begin
        int cyc, nb, ndone;
        logic [3:0] ra, rb;
        logic       rc;
        logic [5:0] e;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);

        do_op("zero",   4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0);
        do_op("7p9",    4'd7,  4'd9,  1'b0, 4'b0000, 1'b1, 1'b0);
        do_op("5p3",    4'd5,  4'd3,  1'b0, 4'b1000, 1'b0, 1'b1);
        do_op("15p15c", 4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0);
        do_op("8p8",    4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1);

        // start and operand changes during RUN must not disturb the captured operation
        @(negedge clk);
        a_in = 4'd5; b_in = 4'd3; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 4'd15; b_in = 4'd15; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrun", cyc, nb);
        chk("midrun_sum", 32'(sum), 32'b1000);
        chk("midrun_cout", 32'(cout), 32'd0);
        chk("midrun_ovf", 32'(ovf), 32'd1);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrun_no_extra_done", 32'(ndone), 32'd0);

        // 8+8 leaves cout=1, so reset is seen clearing it; async reset mid-RUN
        do_op("8p8b", 4'd8, 4'd8, 1'b0, 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        a_in = 4'd1; b_in = 4'd2; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("3p4", 4'd3, 4'd4, 1'b0, 4'b0111, 1'b0, 1'b0);

        // start held through DONE: next operation begins without an IDLE cycle
        do_op("2p5", 4'd2, 4'd5, 1'b0, 4'b0111, 1'b0, 1'b0);
        a_in = 4'd1; b_in = 4'd1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_done_gap", 32'(cyc), 32'd5);
        chk("b2b_sum", 32'(sum), 32'b0010);
        chk("b2b_cout", 32'(cout), 32'd0);

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            e  = ref_add(ra, rb, rc);
            do_op("rand", ra, rb, rc, e[3:0], e[4], e[5]);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_unit.md
Name: serial_adder_unit

Overview:
- Bit-serial N-bit adder, downstream consumer of the NAND half-adder cell (p = carry, q = sum).
- Chains two half-adder stages per cycle into a full adder, with a registered carry, and processes operands LSB-first, one bit per clock.
- Start/busy/done handshake; result, carry-out and signed-overflow flag are held until the next operation.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when not busy
- a_in  input  WIDTH  operand A, captured on an accepted start
- b_in  input  WIDTH  operand B, captured on an accepted start
- cin  input  1  carry-in, captured on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result, LSB-first shift assembly
- cout  output  1  final carry-out
- ovf  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand registers, carry register and bit counter cleared.
  - Takes effect immediately, including mid-RUN.
  - After rst_n returns high, the first accepted start behaves normally.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a_in, b_in into shift registers, carry_reg<=cin, count<=0, sum<=0, ovf<=0, go to RUN.
  - busy becomes 1 after that edge.
- RUN, each edge:
  - Stage 1 half adder: s1 = a0 XOR b0, c1 = a0 AND b0.
  - Stage 2 half adder: s = s1 XOR carry_reg, c2 = s1 AND carry_reg.
  - carry_reg <= c1 OR c2.
  - sum shifts right with s inserted at the MSB. After WIDTH shifts, bit i holds the bit-i result.
  - Operand registers shift right by 1; count <= count+1.
  - When processing bit WIDTH-1 (count==WIDTH-1): ovf <= carry_reg XOR (c1 OR c2), cout <= c1 OR c2, go to DONE.
- DONE:
  - busy=0, done=1 for exactly this one cycle; next edge goes to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are possible: the next edge goes to RUN, not IDLE, and done still lasts one cycle.
- Latency: start sampled at edge E0 → busy high for edges E0..E0+WIDTH (WIDTH RUN edges) → done high in the cycle after edge E0+WIDTH.
  - WIDTH=4: start edge 0, done visible after edge 4, clear after edge 5.
- start while busy (RUN) is ignored: no restart and no queueing.
- a_in, b_in and cin changes after capture have no effect on the current operation.
- sum, cout and ovf hold their last values in IDLE and DONE until the next accepted start clears sum and ovf.
  - cout is overwritten only at the final bit.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1). The result never saturates.
- Counter width: ceil(log2(WIDTH)), minimum 1 bit. No wrap occurs, because the counter exits at WIDTH-1.
- done and busy are never high simultaneously.

Test Plan (WIDTH=4):
- Reset, then start with a=0, b=0, cin=0 → done after 4 RUN cycles; sum=0000, cout=0, ovf=0; busy high exactly 4 cycles.
- a=7, b=9, cin=0 → sum=0000, cout=1, ovf=0. a=5, b=3, cin=0 → sum=1000, cout=0, ovf=1.
- a=15, b=15, cin=1 → sum=1111, cout=1, ovf=0. a=8, b=8, cin=0 → sum=0000, cout=1, ovf=1.
- Pulse start again at RUN cycle 2, and change a_in/b_in mid-RUN → result still matches the captured operands; no extra done pulse.
- Assert rst_n=0 asynchronously (between clock edges) at RUN cycle 2 → busy=0, sum=0, cout=0, ovf=0 immediately; no done pulse. After release, a=3, b=4, cin=0 → sum=0111, cout=0.
- Hold start=1 in the DONE cycle with a=1, b=1 → the new operation starts with no IDLE cycle; second done 5 cycles after the first, with sum=0010.
- Random bench: 200 random operand sets checked against {cout,sum}=a+b+cin and the ovf formula.
